spi_master_engine: RTL

Synthesizable, parametrised SPI master that executes one full-duplex transfer per accepted command, with per-command frame length, chip select and SPI mode (CPOL/CPHA). It sits between the FPGA control logic (register bank or sequencer) and external SPI slaves such as the AFE2256 configuration ports. It generalises the fixed 32-bit, mode-0, single-slave host transfer to N slaves, 1..DATA_W bits, all four modes and a programmable clock divider.

---
 rtl/spi_master_engine.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/spi_master_engine.sv
// spi_master_engine: full-duplex SPI master, one frame per accepted command.
// Each command selects its own frame length (1..DATA_W), chip select and SPI mode.
// SCLK half-period is HALF_DIV clk cycles. At least CS_GAP+1 deselected cycles separate frames.
module spi_master_engine #(
  parameter int DATA_W   = 32,
  parameter int NUM_CS   = 2,
  parameter int HALF_DIV = 5,
  parameter int CS_GAP   = 4,
  localparam int LEN_W   = $clog2(DATA_W + 1),
  localparam int CSEL_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [CSEL_W-1:0] cmd_cs,
  input  logic              cmd_cpol,
  input  logic              cmd_cpha,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              spi_sclk,
  output logic [NUM_CS-1:0] spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int TMR_MAX = (HALF_DIV > CS_GAP) ? HALF_DIV : CS_GAP;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0]  H_LAST   = TMR_W'(HALF_DIV - 1);
  localparam logic [TMR_W-1:0]  G_LAST   = TMR_W'(CS_GAP - 1);
  localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(DATA_W);
  localparam logic [CSEL_W:0]   CS_LIMIT = (CSEL_W + 1)'(NUM_CS);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t            state, state_d;
  logic [TMR_W-1:0]  tmr, tmr_d;
  logic              accept, sclk_edge, enter_gap;
  logic [LEN_W-1:0]  eff_len;
  logic [DATA_W-1:0] tx_init, tx_sr, rx_sr;
  logic [NUM_CS-1:0] cs_dec;
  logic [LEN_W:0]    edge_cnt, edge_total;
  logic              cpha_q, err_q;
  logic              lead_edge, last_edge, shift_now, sample_now;

  // A length of 0, or one beyond DATA_W, means a full-width frame.
  assign eff_len  = (cmd_len == '0 || cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
  // Left-align the frame so its first bit always leaves from the MSB.
  assign tx_init  = cmd_data << (LEN_MAX - eff_len);
  assign busy     = (state != IDLE);

  // edge_cnt counts the edges already issued, so an even count means the next edge is a leading edge.
  assign lead_edge  = ~edge_cnt[0];
  assign last_edge  = (edge_cnt == edge_total - 1'b1);
  assign shift_now  = lead_edge ? cpha_q : (~cpha_q & ~last_edge);
  assign sample_now = lead_edge ^ cpha_q;

  // Decode the chip-select index; out-of-range indexes select nothing.
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if ({1'b0, cmd_cs} == (CSEL_W + 1)'(i)) cs_dec[i] = 1'b0;
    end
  end

  // Next-state logic: a single timer paces the SETUP, SCLK half-periods, HOLD and GAP phases.
  always_comb begin
    state_d   = state;
    tmr_d     = tmr + 1'b1;
    accept    = 1'b0;
    sclk_edge = 1'b0;
    enter_gap = 1'b0;
    unique case (state)
      IDLE: begin
        tmr_d = '0;
        if (cmd_valid && cmd_ready) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: if (tmr == H_LAST) begin
        tmr_d     = '0;
        sclk_edge = 1'b1;
        state_d   = SHIFT;
      end
      SHIFT: if (tmr == H_LAST) begin
        tmr_d = '0;
        if (edge_cnt == edge_total) state_d = HOLD;
        else sclk_edge = 1'b1;
      end
      HOLD: if (tmr == H_LAST) begin
        tmr_d     = '0;
        enter_gap = 1'b1;
        state_d   = GAP;
      end
      GAP: if (tmr == G_LAST) begin
        tmr_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, timer and ready registers; ready is registered so it stays low throughout reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      tmr       <= '0;
      cmd_ready <= 1'b0;
    end else begin
      state     <= state_d;
      tmr       <= tmr_d;
      cmd_ready <= (state_d == IDLE);
    end
  end

  // SPI pins and response outputs, all registered and forced to idle by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spi_sclk  <= 1'b0;
      spi_cs_n  <= '1;
      spi_mosi  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        spi_sclk <= cmd_cpol;
        spi_cs_n <= cs_dec;
        spi_mosi <= cmd_cpha ? 1'b0 : tx_init[DATA_W-1];
      end
      if (sclk_edge) begin
        spi_sclk <= ~spi_sclk;
        if (shift_now) spi_mosi <= tx_sr[DATA_W-1];
      end
      if (enter_gap) begin
        spi_cs_n  <= '1;
        spi_mosi  <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_data  <= rx_sr;
        rsp_err   <= err_q;
      end
    end
  end

  // Frame datapath: the shift registers and the latched command fields are reloaded on every accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      tx_sr      <= cmd_cpha ? tx_init : (tx_init << 1);
      rx_sr      <= '0;
      edge_cnt   <= '0;
      edge_total <= {eff_len, 1'b0};
      cpha_q     <= cmd_cpha;
      err_q      <= ({1'b0, cmd_cs} >= CS_LIMIT);
    end else if (sclk_edge) begin
      edge_cnt <= edge_cnt + 1'b1;
      if (shift_now)  tx_sr <= tx_sr << 1;
      if (sample_now) rx_sr <= {rx_sr[DATA_W-2:0], spi_miso};
    end
  end

endmodule
